prog_loader: RTL

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Boot-image loader: receives a length-prefixed byte stream and writes it word by word
// into core memory, then releases the core from reset. Aborts sticky on error or timeout.
//
// state  | meaning
// HDR    | collecting the 4-byte little-endian word count
// DATA   | collecting the 4 bytes of the next image word
// WRITE  | write command outstanding, waiting for the memory response
// DONE   | image loaded, core released from reset (terminal)
// ERR    | load aborted, core held in reset (terminal)
module prog_loader #(
    parameter int unsigned   AW          = 32,
    parameter int unsigned   DW          = 32,
    parameter logic [AW-1:0] BASE_ADDR   = '0,
    parameter int unsigned   MAX_WORDS   = 4096,
    parameter int unsigned   RSP_TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_byte_valid,
    input  logic [7:0]      i_byte_data,
    output logic            o_byte_ready,
    output logic            o_cmd_valid,
    output logic [AW-1:0]   o_cmd_addr,
    output logic            o_cmd_read,
    output logic [DW-1:0]   o_cmd_wdata,
    output logic [DW/8-1:0] o_cmd_wmask,
    input  logic            i_rsp_valid,
    input  logic            i_rsp_err,
    output logic            o_core_rst_n,
    output logic            o_done,
    output logic            o_err,
    output logic [15:0]     o_word_cnt
);

    // Timer holds RSP_TIMEOUT-1 down to 0, so WRITE lasts at most RSP_TIMEOUT cycles.
    localparam int unsigned TW = (RSP_TIMEOUT > 2) ? $clog2(RSP_TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_HDR   = 3'd0,
        S_DATA  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_armed;
    logic [1:0]      r_byte_cnt;
    logic [31:0]     r_len;
    logic [DW-1:0]   r_shift;
    logic [15:0]     r_word_cnt;
    logic [TW-1:0]   r_tmo;

    logic            w_ready;
    logic            w_byte_acc;
    logic            w_last_byte;
    logic [DW-1:0]   w_word;
    logic [31:0]     w_word32;
    logic [15:0]     w_cnt_inc;
    logic            w_tmo_hit;
    logic            w_rsp_ok;
    logic [AW-1:0]   w_addr;

    assign w_ready     = r_armed && ((r_state == S_HDR) || (r_state == S_DATA));
    assign w_byte_acc  = i_byte_valid && w_ready;
    assign w_last_byte = w_byte_acc && (r_byte_cnt == 2'd3);
    assign w_word      = {i_byte_data, r_shift[DW-1:8]};
    assign w_word32    = w_word[31:0];
    assign w_cnt_inc   = r_word_cnt + 16'd1;
    assign w_tmo_hit   = (r_tmo == '0);
    assign w_rsp_ok    = (r_state == S_WRITE) && i_rsp_valid && !i_rsp_err;
    assign w_addr      = BASE_ADDR + (AW'(r_word_cnt) << 2);

    assign o_cmd_read  = 1'b0;
    assign o_word_cnt  = r_word_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_HDR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        o_byte_ready = 1'b0;
        o_cmd_valid  = 1'b0;
        o_cmd_addr   = '0;
        o_cmd_wdata  = '0;
        o_cmd_wmask  = '0;
        o_core_rst_n = 1'b0;
        o_done       = 1'b0;
        o_err        = 1'b0;
        unique case (r_state)
            S_HDR: begin
                o_byte_ready = w_ready;
                if (w_last_byte) begin
                    if (w_word32 == 32'd0) begin
                        w_next = S_DONE;
                    end else if (w_word32 > 32'(MAX_WORDS)) begin
                        w_next = S_ERR;
                    end else begin
                        w_next = S_DATA;
                    end
                end
            end
            S_DATA: begin
                o_byte_ready = w_ready;
                if (w_last_byte) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                o_cmd_valid = 1'b1;
                o_cmd_addr  = w_addr;
                o_cmd_wdata = r_shift;
                o_cmd_wmask = '1;
                if (i_rsp_valid) begin
                    if (i_rsp_err) begin
                        w_next = S_ERR;
                    end else if ({16'd0, w_cnt_inc} == r_len) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_DATA;
                    end
                end else if (w_tmo_hit) begin
                    w_next = S_ERR;
                end
            end
            S_DONE: begin
                o_core_rst_n = 1'b1;
                o_done       = 1'b1;
            end
            S_ERR: begin
                o_err = 1'b1;
            end
            default: begin
                w_next = S_ERR;
            end
        endcase
    end

    // r_armed keeps the byte port closed while reset is applied and for the first edge after.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_armed    <= 1'b0;
            r_byte_cnt <= 2'd0;
            r_len      <= 32'd0;
            r_shift    <= '0;
            r_word_cnt <= 16'd0;
            r_tmo      <= '0;
        end else begin
            r_armed <= 1'b1;
            if (w_byte_acc) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                r_shift    <= w_word;
            end
            if ((r_state == S_HDR) && w_last_byte) begin
                r_len <= w_word32;
            end
            if ((r_state == S_DATA) && w_last_byte) begin
                r_tmo <= TW'(RSP_TIMEOUT - 1);
            end else if ((r_state == S_WRITE) && !w_tmo_hit) begin
                r_tmo <= r_tmo - TW'(1);
            end
            if (w_rsp_ok) begin
                r_word_cnt <= w_cnt_inc;
            end
        end
    end

endmodule
